// File: rtl/seg_display_pkg.sv
// Shared defaults and width helpers for the seven-segment display multiplexer.
package seg_display_pkg;

  localparam int unsigned DefNumDigits  = 4;
  localparam int unsigned DefSegW       = 7;
  localparam int unsigned DefRefreshDiv = 50000;
  localparam int unsigned DefBlankCyc   = 16;
  localparam logic        DefAnAct      = 1'b1;
  localparam logic        DefSegAct     = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned refresh_div);
    return $clog2(refresh_div);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/refresh_tick.sv
// Per-digit slot counter: flags the last cycle of a slot and the leading blanking window.
module refresh_tick
  import seg_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DefRefreshDiv,
  parameter int unsigned BLANK_CYC   = DefBlankCyc
) (
  input  logic clk,
  input  logic rst,
  output logic o_slot_end,
  output logic o_blank
);

  localparam int unsigned       CntW   = cnt_width(REFRESH_DIV);
  localparam logic [CntW-1:0]   CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_slot_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_slot_end = (r_cnt == CntMax);

  // A zero-length blanking window would make the compare constant, so tie it off.
  if (BLANK_CYC == 0) begin : g_no_blank
    assign o_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
    assign o_blank = (r_cnt < BlankEnd);
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed N-digit seven-segment driver with blanking, per-digit enable,
// configurable polarity and frame-synchronous double buffering.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DefNumDigits,
  parameter int unsigned SEG_W       = DefSegW,
  parameter int unsigned REFRESH_DIV = DefRefreshDiv,
  parameter int unsigned BLANK_CYC   = DefBlankCyc,
  parameter logic        AN_ACT      = DefAnAct,
  parameter logic        SEG_ACT     = DefSegAct
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        load,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic                        frame_done
);

  localparam int unsigned           IdxW   = idx_width(NUM_DIGITS);
  localparam logic [IdxW-1:0]       IdxMax = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{~AN_ACT}};
  localparam logic [SEG_W-1:0]      SegOff = {SEG_W{~SEG_ACT}};

  logic w_slot_end;
  logic w_blank;
  logic w_frame_end;

  refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) u_refresh_tick (
    .clk       (clk),
    .rst       (rst),
    .o_slot_end(w_slot_end),
    .o_blank   (w_blank)
  );

  logic [IdxW-1:0]             r_idx;
  logic [NUM_DIGITS*SEG_W-1:0] r_shd_data, r_act_data;
  logic [NUM_DIGITS-1:0]       r_shd_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]       r_shd_en, r_act_en;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [SEG_W-1:0]            r_seg;
  logic                        r_dp;
  logic                        r_frame_done;

  assign w_frame_end = w_slot_end && (r_idx == IdxMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_idx <= w_frame_end ? '0 : r_idx + IdxW'(1);
    end
  end

  // Shadow catches every load; active only changes between frames, and a load
  // landing exactly on the boundary bypasses the shadow so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_data <= '0;
      r_shd_dp   <= '0;
      r_shd_en   <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_act_en   <= '0;
    end else begin
      if (load) begin
        r_shd_data <= data_in;
        r_shd_dp   <= dp_in;
        r_shd_en   <= digit_en;
      end
      if (w_frame_end) begin
        r_act_data <= load ? data_in  : r_shd_data;
        r_act_dp   <= load ? dp_in    : r_shd_dp;
        r_act_en   <= load ? digit_en : r_shd_en;
      end
    end
  end

  logic [NUM_DIGITS-1:0] w_sel;
  logic [SEG_W-1:0]      w_slice;
  logic                  w_en;
  logic                  w_dp;
  logic                  w_lit;

  always_comb begin
    w_sel   = '0;
    w_slice = '0;
    w_en    = 1'b0;
    w_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_sel[i] = 1'b1;
        w_slice  = r_act_data[(NUM_DIGITS-1-i)*SEG_W +: SEG_W];
        w_en     = r_act_en[i];
        w_dp     = r_act_dp[i];
      end
    end
    w_lit = w_en & ~w_blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an         <= AnOff;
      r_seg        <= SegOff;
      r_dp         <= ~SEG_ACT;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_lit ? (w_sel ^ AnOff) : AnOff;
      r_seg        <= (w_lit ? w_slice : '0) ^ SegOff;
      r_dp         <= (w_lit & w_dp) ^ ~SEG_ACT;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench: two instances (active-high and active-low) driven by one stimulus stream.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an, an_n;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n;
  logic        fd, fd_n;

  always #5 clk = ~clk;

  seg_display_mux #(
    .NUM_DIGITS(4), .SEG_W(7), .REFRESH_DIV(8), .BLANK_CYC(2), .AN_ACT(1'b1), .SEG_ACT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an), .seg(seg), .dp(dp), .frame_done(fd)
  );

  seg_display_mux #(
    .NUM_DIGITS(4), .SEG_W(7), .REFRESH_DIV(8), .BLANK_CYC(2), .AN_ACT(1'b0), .SEG_ACT(1'b0)
  ) dut_inv (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an_n), .seg(seg_n), .dp(dp_n), .frame_done(fd_n)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic finish_req = 1'b0;

  // cyc = number of clock edges since reset release; output after edge k shows slot state k-1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push_frame(input int f, input int n, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpv, input logic [3:0] env);
    logic [6:0] s[4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int j = 0; j < n; j++) begin
      int   d;
      int   c;
      logic lit;
      exp_t e;
      d      = j / 8;
      c      = j % 8;
      lit    = (c >= 2) && env[d];
      e.cyc  = 32 * f + 1 + j;
      e.an   = lit ? (4'b0001 << d) : 4'b0000;
      e.seg  = lit ? s[d] : 7'h00;
      e.dp   = lit ? dpv[d] : 1'b0;
      e.fd   = (j == 31);
      q.push_back(e);
    end
  endtask

  task automatic load_at(input int e, input logic [27:0] d, input logic [3:0] p,
                         input logic [3:0] en);
    while (cyc < e - 1) @(negedge clk);
    data_in  = d;
    dp_in    = p;
    digit_en = en;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check(input string name, input int at, input logic [12:0] got,
                       input logic [12:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b fd=%b want an=%b seg=%h dp=%b fd=%b",
               name, at, got[12:9], got[8:2], got[1], got[0],
               want[12:9], want[8:2], want[1], want[0]);
    end
  endtask

  // Monitor: pops the expected entry stamped for this cycle; checks reset levels while rst is high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (finish_req) begin
        n_vec++;
        if (q.size() != 0) begin
          n_fail++;
          $display("FAIL drain got %0d pending entries want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
      end else if (rst) begin
        #1;
        check("rst_norm", cyc, {an, seg, dp, fd}, {4'h0, 7'h00, 1'b0, 1'b0});
        check("rst_inv", cyc, {an_n, seg_n, dp_n, fd_n}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check("scan_norm", cyc, {an, seg, dp, fd}, {e.an, e.seg, e.dp, e.fd});
        check("scan_inv", cyc, {an_n, seg_n, dp_n, fd_n}, {~e.an, ~e.seg, ~e.dp, e.fd});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    digit_en = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Frame 0 dark; A in frames 1-2; B (digit 2 off) in frame 3; D wins over shadow C from frame 4.
    push_frame(0, 32, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b0000);
    push_frame(1, 32, 7'h7F, 7'h00, 7'h00, 7'h00, 4'b0001, 4'b1111);
    push_frame(2, 32, 7'h7F, 7'h00, 7'h00, 7'h00, 4'b0001, 4'b1111);
    push_frame(3, 32, 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b1010, 4'b1011);
    push_frame(4, 32, 7'h3F, 7'h30, 7'h6D, 7'h79, 4'b0100, 4'b0111);
    push_frame(5, 32, 7'h3F, 7'h30, 7'h6D, 7'h79, 4'b0100, 4'b0111);
    push_frame(6, 5,  7'h3F, 7'h30, 7'h6D, 7'h79, 4'b0100, 4'b0111);

    load_at(5,   {7'h7F, 7'h00, 7'h00, 7'h00}, 4'b0001, 4'b1111);
    load_at(74,  {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1010, 4'b1011);
    load_at(100, {7'h01, 7'h02, 7'h03, 7'h04}, 4'b0000, 4'b1111);
    load_at(128, {7'h3F, 7'h30, 7'h6D, 7'h79}, 4'b0100, 4'b0111);

    // Digit 0 is lit at cycle 197; reset lands mid-cycle.
    while (cyc < 197) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    push_frame(0, 32, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b0000);
    push_frame(1, 32, 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000, 4'b0000);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    finish_req = 1'b1;
  end

endmodule
